// File: rtl/register_file.sv
// register_file
//   Two-read, one-write register file with registered read ports, write-to-read
//   bypass, optional hard-wired zero register and a sequential clear sweep.
//
//   Parameters
//     WIDTH    : data bits per register
//     DEPTH    : number of registers (2**ADDR_W >= DEPTH)
//     ADDR_W   : address bits
//     ZERO_REG : 1 -> register 0 reads as zero and ignores writes
//
//   Ports
//     clock        : single clock, rising edge
//     reset_n      : asynchronous active-low reset
//     write        : write enable
//     write_addr   : register written
//     write_data   : value written
//     read_addr_a  : register read on port A
//     read_addr_b  : register read on port B
//     clear        : start a sweep that zeroes every register, one per cycle
//     read_data_a  : registered port A data (one-cycle latency)
//     read_data_b  : registered port B data (one-cycle latency)
//     busy         : high while the clear sweep is running
module register_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  input  logic              clear,
  output logic [WIDTH-1:0]  read_data_a,
  output logic [WIDTH-1:0]  read_data_b,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] sweep;

  // Per-entry write select; addresses beyond DEPTH match no entry, and the
  // zero register is never selected when ZERO_REG is set.
  logic [DEPTH-1:0]  wr_sel;
  logic              wr_ok;
  logic [WIDTH-1:0]  rd_a_next;
  logic [WIDTH-1:0]  rd_b_next;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (write_addr == ADDR_W'(i) && !(ZERO_REG && i == 0)) begin
        wr_sel[i] = 1'b1;
      end
    end
    // Clear has priority over a write sampled on the same edge.
    wr_ok = (state == IDLE) && write && !clear && (|wr_sel);
  end

  // Read muxes are written as decoded loops so that out-of-range addresses
  // simply select nothing and return zero, with the bypass folded in.
  always_comb begin
    rd_a_next = '0;
    rd_b_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG && i == 0)) begin
        if (read_addr_a == ADDR_W'(i)) begin
          rd_a_next = (wr_ok && wr_sel[i]) ? write_data : mem[i];
        end
        if (read_addr_b == ADDR_W'(i)) begin
          rd_b_next = (wr_ok && wr_sel[i]) ? write_data : mem[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      sweep       <= '0;
      read_data_a <= '0;
      read_data_b <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            // Outputs are forced to zero on entry so they read zero for the
            // whole time busy is high.
            state       <= CLEAR;
            busy        <= 1'b1;
            sweep       <= '0;
            read_data_a <= '0;
            read_data_b <= '0;
          end else begin
            read_data_a <= rd_a_next;
            read_data_b <= rd_b_next;
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (wr_ok && wr_sel[i]) begin
                mem[i] <= write_data;
              end
            end
          end
        end

        CLEAR: begin
          read_data_a <= '0;
          read_data_b <= '0;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sweep == ADDR_W'(i)) begin
              mem[i] <= '0;
            end
          end
          if (sweep == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            sweep <= '0;
          end else begin
            sweep <= sweep + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed bench for register_file. A behavioural model (array of register
//   contents plus a remaining-sweep-cycles count) predicts both read ports and
//   busy; a negedge process compares the DUT to it every cycle. Directed
//   sequences add literal expectations. A second, smaller instance (DEPTH=12)
//   covers addresses beyond DEPTH.
module tb_register_file;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] write_addr = '0;
  logic [WIDTH-1:0]  write_data = '0;
  logic [ADDR_W-1:0] read_addr_a = '0;
  logic [ADDR_W-1:0] read_addr_b = '0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  read_data_a;
  logic [WIDTH-1:0]  read_data_b;
  logic              busy;

  logic              s_write = 1'b0;
  logic [ADDR_W-1:0] s_waddr = '0;
  logic [WIDTH-1:0]  s_wdata = '0;
  logic [ADDR_W-1:0] s_ra = '0;
  logic [ADDR_W-1:0] s_rb = '0;
  logic              s_clear = 1'b0;
  logic [WIDTH-1:0]  s_a;
  logic [WIDTH-1:0]  s_b;
  logic              s_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;

  always #5 clock = ~clock;

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n), .write(write), .write_addr(write_addr),
    .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .clear(clear), .read_data_a(read_data_a), .read_data_b(read_data_b), .busy(busy)
  );

  register_file #(.WIDTH(WIDTH), .DEPTH(12), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) u_small (
    .clock(clock), .reset_n(reset_n), .write(s_write), .write_addr(s_waddr),
    .write_data(s_wdata), .read_addr_a(s_ra), .read_addr_b(s_rb),
    .clear(s_clear), .read_data_a(s_a), .read_data_b(s_b), .busy(s_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] m_a, m_b;
  int               m_left;   // sweep cycles still to run; 0 means idle

  function automatic bit accepted();
    return write && (int'(write_addr) < DEPTH) && (write_addr != 0);
  endfunction

  function automatic logic [WIDTH-1:0] expect_read(input logic [ADDR_W-1:0] addr);
    if (int'(addr) >= DEPTH || addr == 0) return '0;
    if (accepted() && addr == write_addr) return write_data;
    return model[addr];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) model[i] <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_left <= 0;
    end else if (m_left != 0) begin
      model[DEPTH - m_left] <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_left <= m_left - 1;
    end else if (clear) begin
      m_a    <= '0;
      m_b    <= '0;
      m_left <= DEPTH;
    end else begin
      if (accepted()) model[write_addr] <= write_data;
      m_a <= expect_read(read_addr_a);
      m_b <= expect_read(read_addr_b);
    end
  end

  always @(negedge clock) begin
    if (run) begin
      check("cyc_read_a", 32'(read_data_a), 32'(m_a));
      check("cyc_read_b", 32'(read_data_b), 32'(m_b));
      check("cyc_busy",   32'(busy),        32'(m_left != 0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    write = 1'b1; write_addr = a; write_data = d;
    tick();
    write = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clock);
    #1;
    check("reset_read_a", 32'(read_data_a), 32'h0);
    check("reset_read_b", 32'(read_data_b), 32'h0);
    check("reset_busy",   32'(busy),        32'h0);
    reset_n = 1'b1;
    run = 1'b1;

    // Read of reg 5 after reset, then disabled write leaves it at zero.
    read_addr_a = 4'd5;
    tick();
    check("rst_reg5", 32'(read_data_a), 32'h0);
    write = 1'b0; write_addr = 4'd5; write_data = 16'd16;
    tick();
    tick();
    check("nowrite_reg5", 32'(read_data_a), 32'h0);

    // Overwrite sequence 16, 3, then disabled write of 7.
    wr(4'd5, 16'd16);
    check("wr16_reg5", 32'(read_data_a), 32'd16);
    wr(4'd5, 16'd3);
    check("wr3_reg5", 32'(read_data_a), 32'd3);
    write_data = 16'd7;
    tick();
    check("hold_reg5", 32'(read_data_a), 32'd3);

    // Bypass on both ports.
    read_addr_a = 4'd7; read_addr_b = 4'd7;
    wr(4'd7, 16'h00AB);
    check("bypass_a", 32'(read_data_a), 32'h00AB);
    check("bypass_b", 32'(read_data_b), 32'h00AB);
    tick();
    check("stored_7", 32'(read_data_b), 32'h00AB);

    // Zero register.
    read_addr_a = 4'd0;
    wr(4'd0, 16'h1234);
    check("zero_bypass", 32'(read_data_a), 32'h0);
    tick();
    check("zero_stored", 32'(read_data_a), 32'h0);

    // Out-of-range writes on the 12-entry instance.
    s_write = 1'b1; s_waddr = 4'd11; s_wdata = 16'h0055;
    tick();
    s_waddr = 4'd12; s_wdata = 16'h0077; s_ra = 4'd12; s_rb = 4'd11;
    tick();
    check("oor12_read", 32'(s_a), 32'h0);
    check("last_valid", 32'(s_b), 32'h0055);
    s_waddr = 4'd15; s_wdata = 16'h0099; s_ra = 4'd15;
    tick();
    check("oor15_read", 32'(s_a), 32'h0);
    s_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_ra = 4'(i);
      tick();
      check("small_scan", 32'(s_a), (i == 11) ? 32'h0055 : 32'h0);
    end

    // Fill 1..15, then clear with a simultaneous write.
    for (int i = 1; i < DEPTH; i++) wr(4'(i), 16'(16'h1000 + i * 16'h0111));
    read_addr_a = 4'd9;
    tick();
    check("fill_reg9", 32'(read_data_a), 32'h1999);
    read_addr_a = 4'd3; read_addr_b = 4'd9;
    clear = 1'b1; write = 1'b1; write_addr = 4'd3; write_data = 16'hFFFF;
    tick();
    clear = 1'b0;
    check("clear_busy", 32'(busy), 32'h1);
    check("clear_out_a", 32'(read_data_a), 32'h0);
    cnt = 1;
    write_addr = 4'd2; write_data = 16'hBEEF;   // ignored while sweeping
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      cnt++;
      check("sweep_out_b", 32'(read_data_b), 32'h0);
    end
    write = 1'b0;
    check("busy_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      read_addr_a = 4'(i); read_addr_b = 4'(DEPTH - 1 - i);
      tick();
      check("after_clear_a", 32'(read_data_a), 32'h0);
      check("after_clear_b", 32'(read_data_b), 32'h0);
    end

    // Reset part-way through a sweep.
    wr(4'd10, 16'hAAAA);
    wr(4'd15, 16'hF0F0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    check("mid_sweep_busy", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy),        32'h0);
    check("async_a",    32'(read_data_a), 32'h0);
    check("async_b",    32'(read_data_b), 32'h0);
    reset_n = 1'b1;
    read_addr_a = 4'd10; read_addr_b = 4'd15;
    wr(4'd10, 16'h1111);
    check("post_rst_wr", 32'(read_data_a), 32'h1111);
    check("post_rst_15", 32'(read_data_b), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    tick();
    check("post_rst_hold", 32'(read_data_a), 32'h1111);

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
- REQ-001: Parameter WIDTH, default 16, data bits per register.
- REQ-002: Parameter DEPTH, default 16, number of registers.
- REQ-003: Parameter ADDR_W, default 4, address bits; SHALL satisfy 2**ADDR_W >= DEPTH.
- REQ-004: Parameter ZERO_REG, default 1; when 1, register 0 SHALL read as zero and ignore writes.
- REQ-005: clock  input  1  single clock; all state changes on rising edge.
- REQ-006: reset_n  input  1  asynchronous, active-low reset.
- REQ-007: write  input  1  write enable for write port.
- REQ-008: write_addr  input  ADDR_W  register written.
- REQ-009: write_data  input  WIDTH  value written.
- REQ-010: read_addr_a  input  ADDR_W  register read on port A.
- REQ-011: read_addr_b  input  ADDR_W  register read on port B.
- REQ-012: clear  input  1  request to zero all registers by sequential sweep.
- REQ-013: read_data_a  output  WIDTH  registered port A data.
- REQ-014: read_data_b  output  WIDTH  registered port B data.
- REQ-015: busy  output  1  high while clear sweep in progress.

Function
- REQ-016: State machine SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
- REQ-017: In IDLE, write=1, clear=0 at a rising edge SHALL store write_data into write_addr.
- REQ-018: Writes SHALL be ignored when write=0, write_addr >= DEPTH, or write_addr=0 with ZERO_REG=1.
- REQ-019: Reads SHALL have one-cycle latency: read_data_x after edge N equals the register addressed by read_addr_x at edge N.
- REQ-020: Bypass: if a write is accepted at edge N to the same address a port reads at edge N, that port SHALL return write_data after edge N.
- REQ-021: Reads of address >= DEPTH, or of address 0 with ZERO_REG=1, SHALL return 0.
- REQ-022: Ports A and B SHALL be independent; both may read the same address in one cycle.
- REQ-023: clear=1 sampled in IDLE at edge N SHALL enter CLEAR after edge N; any write sampled at edge N SHALL be dropped (clear has priority).
- REQ-024: In CLEAR, a sweep counter SHALL zero register k at edge N+1+k, for k = 0..DEPTH-1.
- REQ-025: After the edge that zeroes register DEPTH-1, state SHALL return to IDLE; busy is high for exactly DEPTH cycles.
- REQ-026: In CLEAR, write and clear inputs SHALL be ignored, and both read_data outputs SHALL be 0.
- REQ-027: The first edge after return to IDLE SHALL resume normal reads and writes.
- REQ-028: Stored values SHALL hold indefinitely when no accepted write or sweep targets them.

Reset
- REQ-029: reset_n=0 SHALL immediately, without waiting for clock, zero all registers, read_data_a, read_data_b, busy, and the sweep counter, and force IDLE.
- REQ-030: reset_n=0 during CLEAR SHALL abort the sweep; the first edge after release behaves as IDLE.

Verification
- REQ-031: Reset then write=0, read_addr_a=5 -> read_data_a=0 after next edge; write=0, write_data=16, write_addr=5 -> register 5 stays 0.
- REQ-032: Write 16 to reg 5, then 3 to reg 5, then write=0 with write_data=7 -> reads of reg 5 give 16, then 3, then 3.
- REQ-033: Same-edge write 0x00AB to reg 7 with read_addr_a=7, read_addr_b=7 -> both outputs 0x00AB after that edge (bypass).
- REQ-034: ZERO_REG=1, write 0x1234 to reg 0 -> reads of reg 0 return 0; write to address >= DEPTH -> no register changes.
- REQ-035: Fill regs 1..15 with nonzero values, pulse clear with simultaneous write -> busy high for 16 cycles, write dropped, outputs 0 while busy, all registers read 0 afterwards.
- REQ-036: Assert reset_n=0 mid-sweep (busy=1, 5 regs cleared) -> busy=0 and outputs 0 immediately; after release, writes accepted on first edge.
